// File: rtl/bcd2binary_seq.sv
// bcd2binary_seq: iterative packed-BCD to unsigned binary converter (reverse double-dabble).
// Each CONV cycle shifts {bcd,bin} right by one, then applies "-3 if >= 8" to every BCD digit.

module bcd2binary_digit_fix (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   // 4-bit subtract only: corrections never borrow across digit boundaries
   assign dout = (din >= 4'd8) ? din - 4'd3 : din;
endmodule

module bcd2binary_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BIN_W-1:0]    bin_out,
   output logic                err
);
   localparam int BCD_W = 4*DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                      state, state_nxt;
   logic [BCD_W-1:0]            bcd_reg;
   logic [BIN_W-1:0]            bin_reg;
   logic [CNT_W-1:0]            cnt;

   logic [BCD_W+BIN_W-1:0]      shifted;
   logic [DIGITS-1:0][3:0]      shift_bcd;
   logic [DIGITS-1:0][3:0]      fix_bcd;
   logic [BIN_W-1:0]            shift_bin;
   logic [DIGITS-1:0]           digit_bad;
   logic                        any_bad;
   logic                        last_iter;

   assign shifted   = {bcd_reg, bin_reg} >> 1;
   assign shift_bcd = shifted[BCD_W+BIN_W-1 -: BCD_W];
   assign shift_bin = shifted[BIN_W-1:0];
   assign last_iter = (cnt == CNT_W'(BIN_W-1));
   assign any_bad   = |digit_bad;
   assign in_ready  = (state == IDLE);

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd2binary_digit_fix u_fix (
         .din  (shift_bcd[g]),
         .dout (fix_bcd[g])
      );
      assign digit_bad[g] = (bcd_in[4*g +: 4] > 4'd9);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = any_bad ? DONE : CONV;
         CONV:    if (last_iter) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_reg   <= '0;
         bin_reg   <= '0;
         cnt       <= '0;
         bin_out   <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (any_bad) begin
                     bin_out   <= '0;
                     err       <= 1'b1;
                     out_valid <= 1'b1;
                  end else begin
                     bcd_reg <= bcd_in;
                     bin_reg <= '0;
                     cnt     <= '0;
                     err     <= 1'b0;
                  end
               end
            end
            CONV: begin
               bcd_reg <= fix_bcd;
               bin_reg <= shift_bin;
               cnt     <= cnt + 1'b1;
               if (last_iter) begin
                  bin_out   <= shift_bin;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
